// File: rtl/seq_detect_pkg.sv
// seq_detect shared types, defaults and helpers.
// Used by seq_detect_param and seq_detect_hist.
package seq_detect_pkg;

  localparam int MAX_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    FILL,
    ARMED
  } det_state_t;

  // Width needed to hold 0..max_w.
  function automatic int len_w(input int max_w);
    return $clog2(max_w + 1);
  endfunction

  // 0 behaves as 1; anything above max_w behaves as max_w.
  function automatic int clamp_len(input int len, input int max_w);
    if (len < 1) return 1;
    if (len > max_w) return max_w;
    return len;
  endfunction

endpackage

// File: rtl/seq_detect_hist.sv
// Serial history shift register plus saturating fill count.
// history[0] holds the newest bit.
module seq_detect_hist
  import seq_detect_pkg::*;
#(
  parameter int MAX_W = MAX_W_DEF,
  parameter int LEN_W = len_w(MAX_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             clr,
  input  logic             din,
  output logic [MAX_W-1:0] hist,
  output logic [LEN_W-1:0] fill
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_W);

  // Clear wins over shift so a same-cycle bit is dropped.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= {hist[MAX_W-2:0], din};
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector with match counter.
// Optional cfg_mask port when SEQ_DETECT_MASK_EN is defined.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int MAX_W = MAX_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = len_w(MAX_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [MAX_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [MAX_W-1:0] cfg_mask,
`endif
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  logic [MAX_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [MAX_W-1:0] mask_q;

  logic [MAX_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic [MAX_W-1:0] win;
  logic [MAX_W-1:0] cmask;
  logic [LEN_W:0]   fill_n;
  det_state_t       state;
  logic             eq;
  logic             hit;
  logic             shift;
  logic             hclr;
  logic             unused_msb;

  assign unused_msb = hist[MAX_W-1];

`ifdef SEQ_DETECT_MASK_EN
  // Mask register: 1 = compare, 0 = don't care.
  always_ff @(posedge clk) begin
    if (reset) mask_q <= '1;
    else if (cfg_load) mask_q <= cfg_mask;
  end
`else
  assign mask_q = '1;
`endif

  // Configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= '0;
      len_q <= LEN_W'(1);
      ovl_q <= 1'b1;
    end else if (cfg_load) begin
      pat_q <= cfg_pattern;
      len_q <= LEN_W'(clamp_len(int'(cfg_len), MAX_W));
      ovl_q <= cfg_overlap;
    end
  end

  // Compare window, ARMED once len-1 bits are held.
  always_comb begin
    cmask = '0;
    for (int i = 0; i < MAX_W; i++)
      cmask[i] = (i < int'(len_q)) && mask_q[i];
    win    = {hist[MAX_W-2:0], in};
    eq     = ((win ^ pat_q) & cmask) == '0;
    fill_n = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    state  = (fill_n >= {1'b0, len_q}) ? ARMED : FILL;
    shift  = in_valid && !cfg_load;
    hit    = shift && (state == ARMED) && eq;
    hclr   = cfg_load || (hit && !ovl_q);
  end

  seq_detect_hist #(
    .MAX_W (MAX_W),
    .LEN_W (LEN_W)
  ) u_hist (
    .clk   (clk),
    .reset (reset),
    .shift (shift),
    .clr   (hclr),
    .din   (in),
    .hist  (hist),
    .fill  (fill)
  );

  // Registered match pulse and saturating counter.
  always_ff @(posedge clk) begin
    if (reset || cfg_load) begin
      out       <= 1'b0;
      match_cnt <= '0;
    end else begin
      out <= hit;
      if (hit && (match_cnt != '1))
        match_cnt <= match_cnt + 1'b1;
    end
  end

  assign busy = (fill != '0);

endmodule
